// File: rtl/enemies_struct.sv
`default_nettype none
// ============================================================================
//  Module      : enemies_struct (package)
//  Description : Shared types for the enemy grid and the player bullet.
//                enemy_t is one grid cell as produced by enemy_control.
//                bullet_state_t is exported so the renderer can read the
//                bullet FSM state.
//  Revision    : 1.0 - initial release
// ============================================================================
package enemies_struct;

  localparam int COORD_W = 12;

  typedef struct packed {
    logic               alive;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } enemy_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLY       = 3'd1,
    S_SCAN      = 3'd2,
    S_HIT_SET   = 3'd3,
    S_HIT_PULSE = 3'd4
  } bullet_state_t;

endpackage
`default_nettype wire

// File: rtl/bullet_hit_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_hit_scan
//  Description : Row-major index counter over the enemy grid plus the
//                point-in-box test of the bullet tip against the currently
//                indexed enemy.
//  Ports       : clk, rst           - clock, async active-high reset
//                enable, freeze     - sync clear / hold
//                clear, advance     - restart at index 0 / step to next cell
//                bullet_x/bullet_y  - bullet top-left
//                enemies            - live grid
//                hit                - indexed enemy contains the tip
//                done               - index is at the last cell
//                tip_x/tip_y        - bullet tip point
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_hit_scan
  import enemies_struct::*;
#(
  parameter int NB_ENEMY_Y   = 10,
  parameter int NB_ENEMY_X   = 5,
  parameter int ENEMY_WIDTH  = 60,
  parameter int ENEMY_HEIGHT = 60,
  parameter int BULLET_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         freeze,
  input  logic         clear,
  input  logic         advance,
  input  logic [11:0]  bullet_x,
  input  logic [11:0]  bullet_y,
  input  enemy_t       enemies [NB_ENEMY_Y][NB_ENEMY_X],
  output logic         hit,
  output logic         done,
  output logic [11:0]  tip_x,
  output logic [11:0]  tip_y
);

  localparam int RW = (NB_ENEMY_Y > 1) ? $clog2(NB_ENEMY_Y) : 1;
  localparam int CW = (NB_ENEMY_X > 1) ? $clog2(NB_ENEMY_X) : 1;
  localparam logic [RW-1:0] c_LAST_R = RW'(NB_ENEMY_Y - 1);
  localparam logic [CW-1:0] c_LAST_C = CW'(NB_ENEMY_X - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  enemy_t        w_cell;
  logic [12:0]   w_x_hi;
  logic [12:0]   w_y_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (!enable) begin
      r_row <= '0;
      r_col <= '0;
    end else if (!freeze) begin
      if (clear) begin
        r_row <= '0;
        r_col <= '0;
      end else if (advance) begin
        if (r_col == c_LAST_C) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign w_cell = enemies[r_row][r_col];
  assign tip_x  = bullet_x + 12'(BULLET_W / 2);
  assign tip_y  = bullet_y;

  // Upper bounds carry one extra bit so boxes near the screen edge do not wrap.
  assign w_x_hi = {1'b0, w_cell.x} + 13'(ENEMY_WIDTH);
  assign w_y_hi = {1'b0, w_cell.y} + 13'(ENEMY_HEIGHT);

  assign hit  = w_cell.alive
              && (w_cell.x <= tip_x) && ({1'b0, tip_x} < w_x_hi)
              && (w_cell.y <= tip_y) && ({1'b0, tip_y} < w_y_hi);
  assign done = (r_row == c_LAST_R) && (r_col == c_LAST_C);

endmodule
`default_nettype wire

// File: rtl/player_bullet_control.sv
`default_nettype none
// ============================================================================
//  Module      : player_bullet_control
//  Description : Owns the player's single bullet: launch on a fire edge,
//                upward steps on frame ticks, and a one-enemy-per-cycle hit
//                scan after each step. A hit produces kill coordinates and a
//                one-cycle strobe for enemy_control.
//  Ports       : clk, rst, enable, freeze, frame_rate, fire
//                player_x/player_y            - player sprite top-left
//                enemies                      - live enemy grid
//                bullet_x/bullet_y/bullet_active
//                killed_enemy_x/killed_enemy_y, valid_enemy_collision
//  Revision    : 1.0 - initial release
// ============================================================================
module player_bullet_control
  import enemies_struct::*;
#(
  parameter int NB_ENEMY_Y   = 10,
  parameter int NB_ENEMY_X   = 5,
  parameter int ENEMY_WIDTH  = 60,
  parameter int ENEMY_HEIGHT = 60,
  parameter int PLAYER_W     = 40,
  parameter int BULLET_W     = 4,
  parameter int BULLET_H     = 12,
  parameter int BULLET_STEP  = 8,
  parameter int MOVE_DIV     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         freeze,
  input  logic         frame_rate,
  input  logic         fire,
  input  logic [11:0]  player_x,
  input  logic [11:0]  player_y,
  input  enemy_t       enemies [NB_ENEMY_Y][NB_ENEMY_X],
  output logic [11:0]  bullet_x,
  output logic [11:0]  bullet_y,
  output logic         bullet_active,
  output logic [11:0]  killed_enemy_x,
  output logic [11:0]  killed_enemy_y,
  output logic         valid_enemy_collision
);

  localparam int SW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [SW-1:0] c_STEP_LAST = SW'(MOVE_DIV - 1);

  bullet_state_t r_state, w_state_nx;
  logic [SW-1:0] r_step, w_step_nx;
  logic          r_fire_q;
  logic [11:0]   r_bx, w_bx_nx, r_by, w_by_nx, r_kx, w_kx_nx, r_ky, w_ky_nx;
  logic          r_active, w_active_nx, r_strobe, w_strobe_nx;
  logic          w_scan_clear, w_scan_adv;
  logic          w_hit, w_done;
  logic [11:0]   w_tip_x, w_tip_y;
  logic          w_fire_edge;
  logic [12:0]   w_launch_y;

  bullet_hit_scan #(
    .NB_ENEMY_Y   (NB_ENEMY_Y),
    .NB_ENEMY_X   (NB_ENEMY_X),
    .ENEMY_WIDTH  (ENEMY_WIDTH),
    .ENEMY_HEIGHT (ENEMY_HEIGHT),
    .BULLET_W     (BULLET_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .freeze   (freeze),
    .clear    (w_scan_clear),
    .advance  (w_scan_adv),
    .bullet_x (r_bx),
    .bullet_y (r_by),
    .enemies  (enemies),
    .hit      (w_hit),
    .done     (w_done),
    .tip_x    (w_tip_x),
    .tip_y    (w_tip_y)
  );

  assign w_fire_edge = fire && !r_fire_q;
  // Bit 12 set means player_y < BULLET_H: the launch would be off-screen.
  assign w_launch_y  = {1'b0, player_y} - 13'(BULLET_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_fire_q <= 1'b0;
      r_bx     <= '0;
      r_by     <= '0;
      r_active <= 1'b0;
      r_kx     <= '0;
      r_ky     <= '0;
      r_strobe <= 1'b0;
    end else if (!enable) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_fire_q <= 1'b0;
      r_bx     <= '0;
      r_by     <= '0;
      r_active <= 1'b0;
      r_kx     <= '0;
      r_ky     <= '0;
      r_strobe <= 1'b0;
    end else if (!freeze) begin
      r_state  <= w_state_nx;
      r_step   <= w_step_nx;
      r_fire_q <= fire;
      r_bx     <= w_bx_nx;
      r_by     <= w_by_nx;
      r_active <= w_active_nx;
      r_kx     <= w_kx_nx;
      r_ky     <= w_ky_nx;
      r_strobe <= w_strobe_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_step_nx    = r_step;
    w_bx_nx      = r_bx;
    w_by_nx      = r_by;
    w_active_nx  = r_active;
    w_kx_nx      = r_kx;
    w_ky_nx      = r_ky;
    w_strobe_nx  = 1'b0;
    w_scan_clear = 1'b0;
    w_scan_adv   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fire_edge && !w_launch_y[12]) begin
          w_bx_nx     = player_x + 12'(PLAYER_W / 2 - BULLET_W / 2);
          w_by_nx     = w_launch_y[11:0];
          w_active_nx = 1'b1;
          w_state_nx  = S_FLY;
        end
      end
      S_FLY: begin
        if (frame_rate) begin
          if (r_step == c_STEP_LAST) begin
            w_step_nx = '0;
            if (r_by <= 12'(BULLET_STEP)) begin
              w_active_nx = 1'b0;
              w_state_nx  = S_IDLE;
            end else begin
              w_by_nx      = r_by - 12'(BULLET_STEP);
              w_scan_clear = 1'b1;
              w_state_nx   = S_SCAN;
            end
          end else begin
            w_step_nx = r_step + 1'b1;
          end
        end
      end
      S_SCAN: begin
        // Coordinates are captured on entry to HIT_SET so they are stable a
        // full cycle before the strobe.
        if (w_hit) begin
          w_kx_nx     = w_tip_x;
          w_ky_nx     = w_tip_y;
          w_active_nx = 1'b0;
          w_state_nx  = S_HIT_SET;
        end else if (w_done) begin
          w_state_nx = S_FLY;
        end else begin
          w_scan_adv = 1'b1;
        end
      end
      S_HIT_SET: begin
        w_strobe_nx = 1'b1;
        w_state_nx  = S_HIT_PULSE;
      end
      S_HIT_PULSE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign bullet_x              = r_bx;
  assign bullet_y              = r_by;
  assign bullet_active         = r_active;
  assign killed_enemy_x        = r_kx;
  assign killed_enemy_y        = r_ky;
  assign valid_enemy_collision = r_strobe;

endmodule
`default_nettype wire

// File: doc/player_bullet_control.md
# player_bullet_control

Owns the player's single bullet: launch on fire, upward flight on frame ticks, and hit detection against the enemy grid. After every step it scans the grid one enemy per cycle. On a hit it drives the kill coordinates and strobe consumed directly by `enemy_control` (`killed_enemy_x/y`, `valid_enemy_collision`). It sits between the player/input logic and `enemy_control`, and its bullet position also feeds the LCD renderer.

## Interface
Parameters:
- `NB_ENEMY_Y`, 10, grid rows
- `NB_ENEMY_X`, 5, grid columns
- `ENEMY_WIDTH`, 60, enemy box width (px)
- `ENEMY_HEIGHT`, 60, enemy box height (px)
- `PLAYER_W`, 40, player sprite width (px)
- `BULLET_W`, 4, bullet width (px)
- `BULLET_H`, 12, bullet height (px)
- `BULLET_STEP`, 8, px moved upward per step
- `MOVE_DIV`, 1, `frame_rate` pulses per step (≥1)

Ports:
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `enable` in 1: low = synchronous clear to reset state
- `freeze` in 1: high = hold all state (pause)
- `frame_rate` in 1: one-cycle frame strobe
- `fire` in 1: fire button level (synchronised upstream)
- `player_x`, `player_y` in 12: player sprite top-left
- `enemies` in `enemy_t [NB_ENEMY_Y][NB_ENEMY_X]`: live grid from `enemy_control`
- `bullet_x`, `bullet_y` out 12: bullet top-left
- `bullet_active` out 1: bullet in flight
- `killed_enemy_x`, `killed_enemy_y` out 12: hit coordinates (bullet tip)
- `valid_enemy_collision` out 1: one-cycle hit strobe

## Operation
- Reset or `enable`=0: every output is 0, the FSM is in IDLE, and the step counter, scan index and `fire_q` are all 0.
- Fire edge: `fire` && !`fire_q`. `fire_q` updates every non-frozen cycle.
- FSM states: IDLE, FLY, SCAN, HIT_SET, HIT_PULSE.
- IDLE: on a fire edge, load `bullet_x` = `player_x` + PLAYER_W/2 − BULLET_W/2 and `bullet_y` = `player_y` − BULLET_H. Set `bullet_active`=1 and go to FLY.
- FLY: each `frame_rate` increments the step counter. When the counter reaches MOVE_DIV−1, clear it and step:
  - If `bullet_y` ≤ BULLET_STEP, clear `bullet_active` and go to IDLE (miss, no strobe).
  - Otherwise `bullet_y` −= BULLET_STEP, set index to 0 and go to SCAN.
- SCAN: test one enemy per cycle in row-major order (r outer, c inner). The tip point is tx = `bullet_x` + BULLET_W/2, ty = `bullet_y`. Hit when alive && x ≤ tx < x+ENEMY_WIDTH && y ≤ ty < y+ENEMY_HEIGHT.
  - The first hit goes to HIT_SET.
  - The last index with no hit returns to FLY.
  - `frame_rate` pulses arriving during SCAN are dropped.
- HIT_SET: register `killed_enemy_x`=tx and `killed_enemy_y`=ty, clear `bullet_active`, go to HIT_PULSE.
- HIT_PULSE: `valid_enemy_collision`=1 for this cycle only, then go to IDLE.
- `killed_enemy_x/y` hold their value until the next HIT_SET. They are never zero on a hit, because ty ≥ 1 is guaranteed by the miss rule.
- A fire edge while not in IDLE is ignored; only one bullet exists.
- `freeze`=1: state, counters, index and outputs all hold, and `frame_rate` is ignored. If HIT_PULSE is frozen, the strobe stays high until `freeze` drops; the downstream block also pauses on freeze.
- Grid values are sampled live during SCAN, so enemy movement mid-scan is tolerated.
- Width rules: upper bounds (x+ENEMY_WIDTH, y+ENEMY_HEIGHT) are computed in 13 bits. The launch y is computed in 13 bits. If `player_y` < BULLET_H, the bullet does not launch.

## Timing
- Fire edge at cycle T: `bullet_active`, `bullet_x/y` valid at T+1.
- Step: `bullet_y` updates the cycle after the qualifying `frame_rate`.
- Scan: 1 to NB_ENEMY_Y·NB_ENEMY_X cycles (50 by default).
- Hit found at index k, cycle S: coordinates change at S+1, strobe at S+2. The coordinates are already stable one cycle before the strobe, which `enemy_control`'s registered compare requires.
- Reset mid-operation: immediate return to the reset state, with no strobe emitted.

## Structure
- `enemy_t` comes from the shared `enemies_struct` package.
- Add `bullet_state_t` (the FSM enum) to the same package so the renderer can read the state.
- One sub-module, `bullet_hit_scan`: a row/column index counter plus the overlap compare, with outputs `hit`, `done` and `tip_x/y`.

## Test plan
- Reset check: assert `rst` -> all outputs 0. Deassert, hold `fire`=1 -> exactly one launch.
- Launch: `player_x`=300, `player_y`=440, fire edge -> next cycle `bullet_x`=318, `bullet_y`=428, `bullet_active`=1. A second fire edge in flight is ignored.
- Miss: all enemies dead, MOVE_DIV=1. Each `frame_rate` plus a 50-cycle scan gives y = 420, 412, … 12, 4. At y=4 the next tick clears `bullet_active`, with no strobe.
- Hit: enemy[2][1] alive at x=300, y=180; bullet at x=318, y=236. The step to 228 hits at scan index 11 -> `killed_enemy_x`=320, `killed_enemy_y`=228, then a one-cycle strobe one cycle later, and `bullet_active`=0.
- Dead skip: same geometry with enemy[2][1].alive=0 and enemy[1][1] alive at y=120 -> no hit at y=228. Flight continues; the hit is reported on enemy[1][1] at y=172.
- Freeze/reset: `freeze` in FLY with 5 frame pulses -> `bullet_y` unchanged. `rst` mid-SCAN -> IDLE, outputs 0, no strobe.
